// File: rtl/sd_kin_sequencer.sv
// rtl/sd_kin_sequencer.sv - command-queued kin sequencer for the sigma-delta modulator (prime, slew, hold, drain)
// Optional replay of queued commands is enabled with `define SDSEQ_LOOP_EN (adds input port loop).
module sd_kin_sequencer #(
    parameter int                  BITWIDTH     = 32,
    parameter int                  DURW         = 16,
    parameter int                  FIFO_DEPTH   = 4,
    parameter logic [BITWIDTH-1:0] RAMP_STEP    = 'h1000,
    parameter int                  PRIME_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [BITWIDTH-1:0] cmd_kin,
    input  logic [DURW-1:0]     cmd_dur,
    input  logic                start,
    input  logic                abort,
`ifdef SDSEQ_LOOP_EN
    input  logic                loop,
`endif
    output logic [BITWIDTH-1:0] kin_out,
    output logic                sd_reset,
    output logic                busy,
    output logic                done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = BITWIDTH + DURW;
    localparam logic [DURW-1:0] PRIME_LOAD = (PRIME_CYCLES < 1) ? DURW'(1) : DURW'(PRIME_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_RAMP,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [BITWIDTH-1:0] kin_q, kin_d;
    logic [BITWIDTH-1:0] tgt_q, tgt_d;
    logic [DURW-1:0]     dur_q, dur_d;
    logic [DURW-1:0]     cnt_q, cnt_d;
    logic                sdr_q, sdr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [PW-1:0]       wr_q, wr_d;
    logic [PW-1:0]       rd_q, rd_d;
    logic [EW-1:0]       mem_q [FIFO_DEPTH];

    logic                full;
    logic                push;
    logic                pop;
    logic                flush;
    logic                avail;
    logic [PW-1:0]       sel_ptr;
    logic [EW-1:0]       head;
    logic [BITWIDTH-1:0] head_kin;
    logic [DURW-1:0]     head_dur;
    logic                to_ramp;
    logic                to_drain;
    logic [BITWIDTH-1:0] ramp_kin;
    logic [DURW-1:0]     ramp_dur;

    // One slew step toward tgt; the difference is taken one bit wider so it cannot overflow.
    function automatic logic [BITWIDTH-1:0] slew(input logic [BITWIDTH-1:0] cur,
                                                 input logic [BITWIDTH-1:0] tgt);
        logic signed [BITWIDTH:0] diff;
        logic        [BITWIDTH:0] mag;
        diff = $signed({tgt[BITWIDTH-1], tgt}) - $signed({cur[BITWIDTH-1], cur});
        mag  = diff[BITWIDTH] ? $unsigned(-diff) : $unsigned(diff);
        if (mag > {1'b0, RAMP_STEP}) begin
            return diff[BITWIDTH] ? (cur - RAMP_STEP) : (cur + RAMP_STEP);
        end
        return tgt;
    endfunction

    assign full      = ((wr_q - rd_q) == PW'(FIFO_DEPTH));
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;

`ifdef SDSEQ_LOOP_EN
    // pl_q is the play position; rd_q stays at the oldest entry while looping so replays are possible.
    logic [PW-1:0] pl_q, pl_d;
    assign sel_ptr = (loop && (pl_q == wr_q)) ? rd_q : pl_q;
    assign avail   = loop ? (rd_q != wr_q) : (pl_q != wr_q);
`else
    assign sel_ptr = rd_q;
    assign avail   = (rd_q != wr_q);
`endif

    assign head     = mem_q[sel_ptr[AW-1:0]];
    assign head_kin = head[EW-1:DURW];
    assign head_dur = head[DURW-1:0];

    always_comb begin
        state_d  = state_q;
        kin_d    = kin_q;
        tgt_d    = tgt_q;
        dur_d    = dur_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        pop      = 1'b0;
        flush    = 1'b0;
        to_ramp  = 1'b0;
        to_drain = 1'b0;
        ramp_kin = tgt_q;
        ramp_dur = dur_q;

        case (state_q)
            S_IDLE: begin
                kin_d = '0;
                if (abort) begin
                    flush = 1'b1;
                end else if (start && avail) begin
                    state_d = S_PRIME;
                    cnt_d   = PRIME_LOAD;
                end
            end
            S_PRIME: begin
                if (abort) begin
                    flush    = 1'b1;
                    to_drain = 1'b1;
                end else if (cnt_q <= DURW'(1)) begin
                    pop      = 1'b1;
                    to_ramp  = 1'b1;
                    ramp_kin = head_kin;
                    ramp_dur = head_dur;
                end else begin
                    cnt_d = cnt_q - DURW'(1);
                end
            end
            S_RAMP: begin
                if (abort) begin
                    flush    = 1'b1;
                    to_drain = 1'b1;
                end else begin
                    to_ramp = 1'b1;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    flush    = 1'b1;
                    to_drain = 1'b1;
                end else if (cnt_q <= DURW'(1)) begin
                    if (avail) begin
                        pop      = 1'b1;
                        to_ramp  = 1'b1;
                        ramp_kin = head_kin;
                        ramp_dur = head_dur;
                    end else begin
                        to_drain = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - DURW'(1);
                end
            end
            S_DRAIN: begin
                flush = abort;
                // The done cycle is spent in DRAIN so busy falls one cycle after done.
                if (done_q) begin
                    state_d = S_IDLE;
                end else begin
                    to_drain = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (to_ramp) begin
            tgt_d = ramp_kin;
            dur_d = ramp_dur;
            kin_d = slew(kin_q, ramp_kin);
            if (kin_d == ramp_kin) begin
                state_d = S_HOLD;
                cnt_d   = (ramp_dur == '0) ? DURW'(1) : ramp_dur;
            end else begin
                state_d = S_RAMP;
            end
        end

        if (to_drain) begin
            state_d = S_DRAIN;
            tgt_d   = '0;
            kin_d   = slew(kin_q, '0);
            done_d  = (kin_d == '0);
        end

        sdr_d  = (state_d == S_IDLE) || (state_d == S_PRIME) || done_d;
        busy_d = (state_d != S_IDLE);

        wr_d = flush ? '0 : (push ? wr_q + PW'(1) : wr_q);
`ifdef SDSEQ_LOOP_EN
        pl_d = flush ? '0 : (pop ? sel_ptr + PW'(1) : pl_q);
        rd_d = flush ? '0 : (loop ? rd_q : pl_d);
`else
        rd_d = flush ? '0 : (pop ? rd_q + PW'(1) : rd_q);
`endif
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_q[AW-1:0]] <= {cmd_kin, cmd_dur};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            kin_q   <= '0;
            tgt_q   <= '0;
            dur_q   <= '0;
            cnt_q   <= '0;
            sdr_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
`ifdef SDSEQ_LOOP_EN
            pl_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            kin_q   <= kin_d;
            tgt_q   <= tgt_d;
            dur_q   <= dur_d;
            cnt_q   <= cnt_d;
            sdr_q   <= sdr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
`ifdef SDSEQ_LOOP_EN
            pl_q    <= pl_d;
`endif
        end
    end

    assign kin_out  = kin_q;
    assign sd_reset = sdr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sd_kin_sequencer.sv
// tb/tb_sd_kin_sequencer.sv - directed and randomized checks of sd_kin_sequencer against a trace-level model
module tb_sd_kin_sequencer;

    localparam int     W     = 32;
    localparam int     DW    = 16;
    localparam longint STEP  = 64'h1000;
    localparam int     PRIME = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_kin;
    logic [DW-1:0] cmd_dur;
    logic          start;
    logic          abort;
    logic [W-1:0]  kin_out;
    logic          sd_reset;
    logic          busy;
    logic          done;

    sd_kin_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_kin   (cmd_kin),
        .cmd_dur   (cmd_dur),
        .start     (start),
        .abort     (abort),
        .kin_out   (kin_out),
        .sd_reset  (sd_reset),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint kin;
        int     dur;
    } cmd_t;

    typedef struct {
        longint kin;
        bit     sdr;
        bit     bsy;
        bit     dn;
    } ent_t;

    int   checks   = 0;
    int   failures = 0;
    cmd_t cmds[$];
    ent_t exp_q[$];
    int   nd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic longint stepto(input longint c, input longint t);
        if (t - c > STEP)  return c + STEP;
        if (t - c < -STEP) return c - STEP;
        return t;
    endfunction

    task automatic add_drain(input longint from);
        longint c;
        c = from;
        do begin
            c = stepto(c, 0);
            exp_q.push_back('{kin: c, sdr: (c == 0), bsy: 1'b1, dn: (c == 0)});
        end while (c != 0);
        exp_q.push_back('{kin: 0, sdr: 1'b1, bsy: 1'b0, dn: 1'b0});
    endtask

    // Expected per-cycle trace, entry 0 is the cycle after start.
    task automatic build();
        longint c;
        int     h;
        exp_q.delete();
        for (int i = 0; i < PRIME; i++) exp_q.push_back('{kin: 0, sdr: 1'b1, bsy: 1'b1, dn: 1'b0});
        c = 0;
        foreach (cmds[i]) begin
            do begin
                c = stepto(c, cmds[i].kin);
                exp_q.push_back('{kin: c, sdr: 1'b0, bsy: 1'b1, dn: 1'b0});
            end while (c != cmds[i].kin);
            h = (cmds[i].dur == 0) ? 1 : cmds[i].dur;
            for (int j = 1; j < h; j++) exp_q.push_back('{kin: c, sdr: 1'b0, bsy: 1'b1, dn: 1'b0});
        end
        nd = exp_q.size();
        add_drain(c);
    endtask

    task automatic push(input longint k, input int d);
        cmd_kin   = k[W-1:0];
        cmd_dur   = d[DW-1:0];
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic push_all();
        foreach (cmds[i]) push(cmds[i].kin, cmds[i].dur);
    endtask

    task automatic run(input int push_at, input longint px_kin, input int px_dur, input int abort_at);
        ent_t e;
        start = 1'b1;
        for (int k = 1; k <= exp_q.size() && k < 2000; k++) begin
            @(posedge clk); #1;
            start     = 1'b0;
            abort     = 1'b0;
            cmd_valid = 1'b0;
            e = exp_q[k-1];
            chk($sformatf("kin@%0d", k), kin_out, e.kin[W-1:0]);
            chk($sformatf("sd_reset@%0d", k), sd_reset, e.sdr);
            chk($sformatf("busy@%0d", k), busy, e.bsy);
            chk($sformatf("done@%0d", k), done, e.dn);
            if (push_at > 0 && k == push_at - 1) chk("ready_full", cmd_ready, 1'b0);
            if (k == push_at) begin
                chk("ready_after_pop", cmd_ready, 1'b1);
                cmd_kin   = px_kin[W-1:0];
                cmd_dur   = px_dur[DW-1:0];
                cmd_valid = 1'b1;
            end
            if (k == abort_at) begin
                abort = 1'b1;
                while (exp_q.size() > k) exp_q.delete(exp_q.size() - 1);
                add_drain(e.kin);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        cmd_valid = 1'b0;
    endtask

    task automatic check_start_ignored(input string tag);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_busy"}, busy, 1'b0);
            chk({tag, "_sdr"}, sd_reset, 1'b1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int     n;
        int     ab;
        longint a;

        reset = 1'b1; cmd_valid = 1'b0; cmd_kin = '0; cmd_dur = '0; start = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_kin", kin_out, 0);
        chk("rst_sdr", sd_reset, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", cmd_ready, 1'b1);
        reset = 1'b0;
        @(posedge clk); #1;

        check_start_ignored("empty_start");

        cmds = '{'{kin: 64'h3000, dur: 4}};
        push_all(); build(); run(0, 0, 0, 0);

        cmds = '{'{kin: -64'sh1800, dur: 1}};
        push_all(); build(); run(0, 0, 0, 0);

        cmds = '{'{kin: 64'h2800, dur: 0}};
        push_all(); build(); run(0, 0, 0, 0);

        cmds = '{'{kin: 64'h2000, dur: 2}, '{kin: -64'sh1000, dur: 3}, '{kin: -64'sh1000, dur: 1},
                 '{kin: 64'h4800, dur: 2}};
        push_all();
        chk("ready_when_full", cmd_ready, 1'b0);
        cmds.push_back('{kin: 64'h0800, dur: 2});
        build(); run(3, 64'h0800, 2, 0);

        cmds = '{'{kin: 64'h2000, dur: 100}, '{kin: 64'h5000, dur: 3}, '{kin: -64'sh3000, dur: 2}};
        push_all(); build(); run(0, 0, 0, PRIME + 1 + 10);
        chk("ready_after_abort", cmd_ready, 1'b1);
        check_start_ignored("flushed_start");

        cmds = '{'{kin: 64'h4000, dur: 3}};
        push_all(); build(); run(0, 0, 0, 1);

        for (int it = 0; it < 8; it++) begin
            cmds.delete();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                a = longint'($urandom_range(0, 32'hC000)) - 64'h6000;
                cmds.push_back('{kin: a, dur: $urandom_range(0, 4)});
            end
            push_all(); build();
            ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, nd) : 0;
            run(0, 0, 0, ab);
        end

        cmds = '{'{kin: 64'h5000, dur: 2}};
        push_all(); push(64'h1000, 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("pre_reset_kin", kin_out, 64'h2000);
        reset = 1'b1;
        #1;
        chk("async_kin", kin_out, 0);
        chk("async_sdr", sd_reset, 1'b1);
        chk("async_busy", busy, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_ready", cmd_ready, 1'b1);
        check_start_ignored("post_reset_start");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
